// File: rtl/neuron_input_loader_if.sv
// Bundles the upstream sample stream and the neuron-controller side of the input loader.
// Stream handshake: a sample transfers on a rising clk edge where in_valid and in_ready are both 1;
// the sender holds in_valid/in_data stable until that edge, and in_ready never depends on in_valid.
interface neuron_input_loader_if #(
    parameter int N  = 10,
    parameter int DW = 8
);
    localparam int AW = $clog2(N);

    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          neu_start;
    logic [AW-1:0] neu_offset;
    logic          neu_read;
    logic [DW-1:0] neu_data;
    logic          neu_ready;

    modport master (
        output in_valid, in_data, neu_offset, neu_read, neu_ready,
        input  in_ready, neu_start, neu_data
    );

    modport slave (
        input  in_valid, in_data, neu_offset, neu_read, neu_ready,
        output in_ready, neu_start, neu_data
    );
endinterface

// File: rtl/neuron_input_loader.sv
// Single-buffered feeder: fills N samples from a stream, starts the neuron, serves its reads
// until the neuron reports done, then returns to filling.
module neuron_input_loader #(
    parameter int N  = 10,
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    neuron_input_loader_if.slave bus,
    output logic                 busy,
    output logic                 vec_done,
    output logic                 err,
    output logic [1:0]           state_dbg
);
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);
    localparam logic [AW:0]   N_W  = (AW + 1)'(N);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_START = 2'd1,
        S_SERVE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   wr_ptr;
    logic [DW-1:0]   buf_mem [N];
    logic [DW-1:0]   neu_data_q;
    logic            err_q;
    logic            accept;
    logic            read_en;
    logic            offset_ok;

    assign accept    = (state == S_FILL) && bus.in_valid;
    assign read_en   = (state == S_SERVE) && bus.neu_read;
    assign offset_ok = {1'b0, bus.neu_offset} < N_W;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_FILL;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FILL:  if (accept && (wr_ptr == LAST)) state_next = S_START;
            S_START: state_next = S_SERVE;
            S_SERVE: if (bus.neu_ready) state_next = S_DONE;
            S_DONE:  state_next = S_FILL;
            default: state_next = S_FILL;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == S_FILL);
        bus.neu_start = (state == S_START);
        vec_done      = (state == S_DONE);
        busy          = (state != S_FILL);
        state_dbg     = state;
    end

    // The buffer is only written in FILL, so reads in SERVE always see a stable vector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            neu_data_q <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < N; i++) buf_mem[i] <= '0;
        end else begin
            if (accept) begin
                buf_mem[wr_ptr] <= bus.in_data;
                wr_ptr          <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (read_en) begin
                if (offset_ok) begin
                    neu_data_q <= buf_mem[bus.neu_offset];
                end else begin
                    neu_data_q <= '0;
                    err_q      <= 1'b1;
                end
            end
        end
    end

    assign bus.neu_data = neu_data_q;
    assign err          = err_q;
endmodule

// File: tb/tb_neuron_input_loader.sv
// Directed bench for neuron_input_loader: fill, serve, stalls, bad offset, completion, reset.
module tb_neuron_input_loader;
    localparam int N  = 10;
    localparam int DW = 8;

    logic       clk;
    logic       rst;
    logic       busy;
    logic       vec_done;
    logic       err;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    neuron_input_loader_if #(.N(N), .DW(DW)) bus ();

    neuron_input_loader #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .vec_done  (vec_done),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        bus.neu_read = 1'b0; bus.neu_offset = '0; bus.neu_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (bus.neu_data !== 8'd0) begin errors++; $display("FAIL reset_neu_data: got %0d want 0", bus.neu_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (bus.neu_start !== 1'b0 || vec_done !== 1'b0) begin errors++; $display("FAIL reset_pulses: start %b done %b want 0 0", bus.neu_start, vec_done); end
        rst = 1'b1;
        // Partial vector, then an asynchronous reset in the middle of it
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.in_data = 8'(99 - i);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || busy !== 1'b0 || state_dbg !== 2'd0) begin
            errors++; $display("FAIL midfill_reset: in_ready %b busy %b state %0d want 1 0 0", bus.in_ready, busy, state_dbg);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            checks++; if (bus.neu_start !== 1'b0 || bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL fill_idle_%0d: start %b in_ready %b want 0 1", i, bus.neu_start, bus.in_ready);
            end
            bus.in_valid = 1'b1; bus.in_data = 8'(i + 1);
        end
        @(negedge clk);
        bus.in_data = 8'd55;  // offered while not ready; must never land in the buffer
        checks++; if (bus.neu_start !== 1'b1 || bus.in_ready !== 1'b0 || state_dbg !== 2'd1) begin
            errors++; $display("FAIL fill_start: start %b in_ready %b state %0d want 1 0 1", bus.neu_start, bus.in_ready, state_dbg);
        end
        @(negedge clk);
        checks++; if (bus.neu_start !== 1'b0 || bus.in_ready !== 1'b0 || state_dbg !== 2'd2) begin
            errors++; $display("FAIL fill_after_start: start %b in_ready %b state %0d want 0 0 2", bus.neu_start, bus.in_ready, state_dbg);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic serve_offsets(input bit descending);
        logic [DW-1:0] exp;
        logic [DW-1:0] base;
        base = descending ? 8'd11 : 8'd1;
        for (int i = 0; i <= N; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp = exp_q.pop_front();
                checks++; if (bus.neu_data !== exp) begin
                    errors++; $display("FAIL serve_data_%0d: got %0d want %0d", i - 1, bus.neu_data, exp);
                end
            end
            if (i < N) begin
                bus.neu_read = 1'b1;
                bus.neu_offset = descending ? 4'(N - 1 - i) : 4'(i);
                exp_q.push_back(base + 8'(bus.neu_offset));
            end else begin
                bus.neu_read = 1'b0;
            end
        end
    endtask

    task automatic test_serve();
        serve_offsets(1'b0);
        bus.neu_offset = 4'd2;
        @(negedge clk);
        checks++; if (bus.neu_data !== 8'd10) begin errors++; $display("FAIL serve_hold: got %0d want 10", bus.neu_data); end
        bus.neu_read = 1'b1; bus.neu_offset = 4'd3;
        @(negedge clk);
        checks++; if (bus.neu_data !== 8'd4) begin errors++; $display("FAIL serve_repeat_a: got %0d want 4", bus.neu_data); end
        @(negedge clk);
        checks++; if (bus.neu_data !== 8'd4) begin errors++; $display("FAIL serve_repeat_b: got %0d want 4", bus.neu_data); end
        bus.neu_read = 1'b0;
    endtask

    task automatic test_bad_offset();
        @(negedge clk);
        bus.neu_read = 1'b1; bus.neu_offset = 4'd12;
        @(negedge clk);
        bus.neu_read = 1'b0;
        checks++; if (bus.neu_data !== 8'd0 || err !== 1'b1) begin
            errors++; $display("FAIL bad_offset: data %0d err %b want 0 1", bus.neu_data, err);
        end
        bus.neu_read = 1'b1; bus.neu_offset = 4'd5;
        @(negedge clk);
        bus.neu_read = 1'b0;
        checks++; if (bus.neu_data !== 8'd6 || err !== 1'b1) begin
            errors++; $display("FAIL bad_offset_sticky: data %0d err %b want 6 1", bus.neu_data, err);
        end
    endtask

    task automatic finish_vector(input logic [DW-1:0] last_val);
        @(negedge clk);
        bus.neu_ready = 1'b1; bus.neu_read = 1'b1; bus.neu_offset = 4'd9;
        @(negedge clk);
        bus.neu_ready = 1'b0; bus.neu_read = 1'b0;
        checks++; if (vec_done !== 1'b1 || state_dbg !== 2'd3 || bus.neu_data !== last_val) begin
            errors++; $display("FAIL complete_done: vec_done %b state %0d data %0d want 1 3 %0d", vec_done, state_dbg, bus.neu_data, last_val);
        end
        @(negedge clk);
        checks++; if (vec_done !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL complete_refill: vec_done %b in_ready %b busy %b want 0 1 0", vec_done, bus.in_ready, busy);
        end
    endtask

    task automatic test_complete();
        finish_vector(8'd10);
        bus.neu_ready = 1'b1; bus.neu_read = 1'b1; bus.neu_offset = 4'd0;
        @(negedge clk);
        bus.neu_ready = 1'b0; bus.neu_read = 1'b0;
        checks++; if (state_dbg !== 2'd0 || bus.neu_data !== 8'd10 || vec_done !== 1'b0) begin
            errors++; $display("FAIL fill_ignores_neuron: state %0d data %0d vec_done %b want 0 10 0", state_dbg, bus.neu_data, vec_done);
        end
    endtask

    task automatic test_stall();
        for (int c = 0; c < 2 * N; c++) begin
            @(negedge clk);
            checks++; if (bus.neu_start !== (c == 2 * N - 1)) begin
                errors++; $display("FAIL stall_start_%0d: got %b want %b", c, bus.neu_start, (c == 2 * N - 1));
            end
            bus.in_valid = (c % 2 == 0);
            bus.in_data  = (c % 2 == 0) ? 8'(11 + c / 2) : 8'hEE;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL stall_serve_state: got %0d want 2", state_dbg); end
    endtask

    task automatic test_second_vector();
        serve_offsets(1'b1);
        finish_vector(8'd20);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky_vec: got %b want 1", err); end
    endtask

    task automatic test_err_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (err !== 1'b0 || bus.neu_data !== 8'd0) begin
            errors++; $display("FAIL err_reset: err %b data %0d want 0 0", err, bus.neu_data);
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_serve();
        test_bad_offset();
        test_complete();
        test_stall();
        test_second_vector();
        test_err_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
